// File: rtl/ps_setpoint_coeff_sequencer.sv
// Purpose: shadow-buffered coefficient loader for the PS setpoint calculator tables.
// Latency: commit -> dinToggle edge -> BUSY_CYCLES drain -> one read cycle -> 4*RESULT_COUNT contiguous strobes.
// Backpressure: none; CPU writes outside IDLE are dropped and flagged in writeRejected.
//
// Ports:
//   clk, reset                       system clock, asynchronous active-high reset
//   cpuWriteStrobe/Table/Address/Data shadow RAM write port (accepted only in IDLE)
//   commitRequest                    single-cycle pulse arming a shadow->table copy
//   statusClear                      clears the sticky overrunError/writeRejected flags
//   dinToggle                        calculator sample toggle; an edge marks a FOFB burst start
//   *WriteStrobe, writeAddress/Data  registered calculator table write port
//   commitPending, overrunError, writeRejected, commitCount  status
module ps_setpoint_coeff_sequencer #(
  parameter int RESULT_COUNT       = 24,
  parameter int RESULT_COUNT_WIDTH = 5,
  parameter int DBUS_WIDTH         = 32,
  parameter int BUSY_CYCLES        = 32,
  parameter int TIMEOUT_CYCLES     = 2000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpuWriteStrobe,
  input  logic [1:0]                    cpuTable,
  input  logic [RESULT_COUNT_WIDTH-1:0] cpuAddress,
  input  logic [DBUS_WIDTH-1:0]         cpuData,
  input  logic                          commitRequest,
  input  logic                          statusClear,
  input  logic                          dinToggle,
  output logic                          gainWriteStrobe,
  output logic                          ffbClipWriteStrobe,
  output logic                          psOffsetWriteStrobe,
  output logic                          psClipWriteStrobe,
  output logic [RESULT_COUNT_WIDTH-1:0] writeAddress,
  output logic [DBUS_WIDTH-1:0]         writeData,
  output logic                          commitPending,
  output logic                          overrunError,
  output logic                          writeRejected,
  output logic [15:0]                   commitCount
);

  localparam int SHADOW_DEPTH = 4 * RESULT_COUNT;
  localparam int IDX_W        = $clog2(SHADOW_DEPTH);
  localparam int TO_W         = $clog2(TIMEOUT_CYCLES);
  localparam int DR_W         = $clog2(BUSY_CYCLES);
  localparam int RCW          = RESULT_COUNT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2,
    ST_COPY  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                    toggle_q;
  logic                    toggle_edge;
  logic [TO_W-1:0]         timeout_cnt;
  logic                    timeout_hit;
  logic [DR_W-1:0]         drain_cnt;
  logic                    drain_zero;
  logic [1:0]              copy_tbl;
  logic [RCW-1:0]          copy_ch;
  logic                    copy_done;
  logic                    copy_ch_last;
  logic                    copy_last;

  logic                    addr_ok;
  logic                    shadow_we;
  logic                    reject_evt;
  logic                    overrun_evt;
  logic                    copy_rd;
  logic                    commit_done;
  logic [3:0]              strobe_nxt;
  logic [IDX_W-1:0]        shadow_wr_idx;
  logic [IDX_W-1:0]        shadow_rd_idx;

  logic [DBUS_WIDTH-1:0]   shadow [SHADOW_DEPTH];

  // ------------------------------------------------------------------
  // Derived conditions
  // ------------------------------------------------------------------
  assign toggle_edge  = dinToggle ^ toggle_q;
  assign timeout_hit  = (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign drain_zero   = (drain_cnt == '0);
  assign copy_ch_last = (copy_ch == RCW'(RESULT_COUNT - 1));
  assign copy_last    = (copy_tbl == 2'd3) && copy_ch_last;

  // Extra bit so the range check stays correct when RESULT_COUNT is a power of two.
  assign addr_ok = ({1'b0, cpuAddress} < (RCW + 1)'(RESULT_COUNT));

  assign shadow_wr_idx = IDX_W'(cpuTable) * IDX_W'(RESULT_COUNT) + IDX_W'(cpuAddress);
  assign shadow_rd_idx = IDX_W'(copy_tbl) * IDX_W'(RESULT_COUNT) + IDX_W'(copy_ch);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (commitRequest) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // A burst start takes priority; the timeout only covers a stalled toggle.
        if (toggle_edge)      state_nxt = ST_DRAIN;
        else if (timeout_hit) state_nxt = ST_COPY;
      end
      ST_DRAIN: begin
        if (drain_zero) state_nxt = ST_COPY;
      end
      ST_COPY: begin
        // copy_done is set after the last read, so this cycle carries the last strobe.
        if (copy_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output / control decode
  // ------------------------------------------------------------------
  always_comb begin
    shadow_we   = 1'b0;
    reject_evt  = 1'b0;
    overrun_evt = 1'b0;
    copy_rd     = 1'b0;
    commit_done = 1'b0;
    strobe_nxt  = 4'b0000;
    case (state)
      ST_IDLE: begin
        // A write in the commit cycle lands before the copy and is included.
        shadow_we = cpuWriteStrobe && addr_ok;
      end
      ST_COPY: begin
        reject_evt  = cpuWriteStrobe;
        overrun_evt = toggle_edge;
        copy_rd     = !copy_done;
        commit_done = copy_done;
        if (!copy_done) strobe_nxt[copy_tbl] = 1'b1;
      end
      default: begin
        reject_evt = cpuWriteStrobe;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Shadow RAM (not reset; contents survive a reset for re-commit)
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (shadow_we) shadow[shadow_wr_idx] <= cpuData;
  end

  // ------------------------------------------------------------------
  // Counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q    <= 1'b0;
      timeout_cnt <= '0;
      drain_cnt   <= '0;
      copy_tbl    <= 2'd0;
      copy_ch     <= '0;
      copy_done   <= 1'b0;
    end else begin
      toggle_q <= dinToggle;

      if (state == ST_IDLE)       timeout_cnt <= '0;
      else if (state == ST_ARMED) timeout_cnt <= timeout_cnt + TO_W'(1);

      if (state == ST_ARMED && toggle_edge)        drain_cnt <= DR_W'(BUSY_CYCLES - 1);
      else if (state == ST_DRAIN && !drain_zero)   drain_cnt <= drain_cnt - DR_W'(1);

      // Table/channel pair walks the shadow in gain, ffbClip, psOffset, psClip order.
      if (state != ST_COPY) begin
        copy_tbl  <= 2'd0;
        copy_ch   <= '0;
        copy_done <= 1'b0;
      end else if (copy_rd) begin
        if (copy_ch_last) begin
          copy_ch  <= '0;
          copy_tbl <= copy_tbl + 2'd1;
        end else begin
          copy_ch  <= copy_ch + RCW'(1);
        end
        if (copy_last) copy_done <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gainWriteStrobe     <= 1'b0;
      ffbClipWriteStrobe  <= 1'b0;
      psOffsetWriteStrobe <= 1'b0;
      psClipWriteStrobe   <= 1'b0;
      writeAddress        <= '0;
      writeData           <= '0;
      commitPending       <= 1'b0;
      overrunError        <= 1'b0;
      writeRejected       <= 1'b0;
      commitCount         <= 16'd0;
    end else begin
      gainWriteStrobe     <= strobe_nxt[0];
      ffbClipWriteStrobe  <= strobe_nxt[1];
      psOffsetWriteStrobe <= strobe_nxt[2];
      psClipWriteStrobe   <= strobe_nxt[3];

      // The shadow read and the strobe share this register stage.
      if (copy_rd) begin
        writeAddress <= copy_ch;
        writeData    <= shadow[shadow_rd_idx];
      end

      commitPending <= (state_nxt != ST_IDLE);

      if (commit_done) commitCount <= commitCount + 16'd1;

      // Set events win over a simultaneous clear.
      if (overrun_evt)      overrunError <= 1'b1;
      else if (statusClear) overrunError <= 1'b0;

      if (reject_evt)       writeRejected <= 1'b1;
      else if (statusClear) writeRejected <= 1'b0;
    end
  end

endmodule
